// File: rtl/ddram_arb_pkg.sv
// Shared types and default widths for the two-requester DDR3 port arbiter.
package ddram_arb_pkg;

  localparam int DEF_AW       = 29;
  localparam int DEF_DW       = 64;
  localparam int DEF_BW       = 8;
  localparam int DEF_RD_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WBURST
  } state_e;

  typedef struct packed {
    logic              id;
    logic [DEF_BW-1:0] len;
  } tag_t;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [DEF_BW-1:0] eff_len(input logic [DEF_BW-1:0] bc);
    return (bc == '0) ? DEF_BW'(1) : bc;
  endfunction

endpackage

// File: rtl/ddram_arb_tagfifo.sv
// Tag FIFO remembering which requester owns each outstanding read burst.
module ddram_arb_tagfifo
  import ddram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_RD_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  tag_t wdata,
  input  logic pop,
  output tag_t rdata,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  tag_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ddram_arb.sv
// Shares one Avalon-MM DDR3 port between two masters, granting whole commands.
// Define DDRAM_ARB_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int BW       = DEF_BW,
  parameter int RD_DEPTH = DEF_RD_DEPTH
) (
  input  logic              ram_clk,
  input  logic              reset_n,
  input  logic [2*AW-1:0]   m_address,
  input  logic [2*BW-1:0]   m_burstcount,
  input  logic [1:0]        m_read,
  input  logic [1:0]        m_write,
  input  logic [2*DW-1:0]   m_writedata,
  input  logic [2*DW/8-1:0] m_byteenable,
  output logic [1:0]        m_waitrequest,
  output logic [DW-1:0]     m_readdata,
  output logic [1:0]        m_readdatavalid,
  output logic [AW-1:0]     ram_address,
  output logic [BW-1:0]     ram_burstcount,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DW-1:0]     ram_writedata,
  output logic [DW/8-1:0]   ram_byteenable,
  input  logic              ram_waitrequest,
  input  logic [DW-1:0]     ram_readdata,
  input  logic              ram_readdatavalid,
  output logic              rd_orphan
);

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   bc_q, bc_d;
  logic [BW-1:0]   ret_cnt_q, ret_cnt_d;
  logic            orphan_q, orphan_d;
  logic [1:0]      elig;
  logic            win, cmd_done, push, pop, fifo_full, fifo_empty;
  tag_t            head;
  logic [AW-1:0]   g_addr;
  logic [BW-1:0]   g_bc;
  logic            g_read, g_write;
  logic [DW-1:0]   g_wdata;
  logic [DW/8-1:0] g_be;

  assign elig = m_write | (m_read & {2{~fifo_full}});

`ifdef DDRAM_ARB_PRIO_EN
  assign win = ~elig[0];
`else
  logic last_q;

  assign win = (elig == 2'b11) ? ~last_q : ~elig[0];

  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n)      last_q <= 1'b1;
    else if (cmd_done) last_q <= grant_q;
  end
`endif

  assign g_addr  = grant_q ? m_address[2*AW-1:AW]        : m_address[AW-1:0];
  assign g_bc    = grant_q ? m_burstcount[2*BW-1:BW]     : m_burstcount[BW-1:0];
  assign g_wdata = grant_q ? m_writedata[2*DW-1:DW]      : m_writedata[DW-1:0];
  assign g_be    = grant_q ? m_byteenable[2*DW/8-1:DW/8] : m_byteenable[DW/8-1:0];
  assign g_read  = m_read[grant_q] & ~m_write[grant_q];
  assign g_write = m_write[grant_q];

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    beats_d        = beats_q;
    addr_d         = addr_q;
    bc_d           = bc_q;
    cmd_done       = 1'b0;
    push           = 1'b0;
    ram_address    = '0;
    ram_burstcount = '0;
    ram_read       = 1'b0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    ram_byteenable = '0;
    m_waitrequest  = 2'b11;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ram_address              = g_addr;
        ram_burstcount           = g_bc;
        ram_read                 = g_read;
        ram_write                = g_write;
        ram_writedata            = g_wdata;
        ram_byteenable           = g_be;
        m_waitrequest[grant_q]   = ram_waitrequest;
        cmd_done                 = (g_read | g_write) & ~ram_waitrequest;
        if (cmd_done) begin
          state_d = IDLE;
          if (!g_write) begin
            push = 1'b1;
          end else if (eff_len(g_bc) > DEF_BW'(1)) begin
            beats_d = eff_len(g_bc) - 1'b1;
            addr_d  = g_addr;
            bc_d    = g_bc;
            state_d = WBURST;
          end
        end
      end
      WBURST: begin
        // Address and burstcount stay at the values of the first beat.
        ram_address            = addr_q;
        ram_burstcount         = bc_q;
        ram_write              = g_write;
        ram_writedata          = g_wdata;
        ram_byteenable         = g_be;
        m_waitrequest[grant_q] = ram_waitrequest;
        if (g_write && !ram_waitrequest) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == BW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_readdatavalid = 2'b00;
    pop             = 1'b0;
    ret_cnt_d       = ret_cnt_q;
    orphan_d        = orphan_q;
    if (ram_readdatavalid) begin
      if (fifo_empty) begin
        orphan_d = 1'b1;
      end else begin
        m_readdatavalid[head.id] = 1'b1;
        if (ret_cnt_q == eff_len(head.len) - 1'b1) begin
          pop       = 1'b1;
          ret_cnt_d = '0;
        end else begin
          ret_cnt_d = ret_cnt_q + 1'b1;
        end
      end
    end
  end

  assign m_readdata = ram_readdata;
  assign rd_orphan  = orphan_q;

  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      beats_q   <= '0;
      ret_cnt_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      beats_q   <= beats_d;
      ret_cnt_q <= ret_cnt_d;
      orphan_q  <= orphan_d;
    end
  end

  always_ff @(posedge ram_clk) begin
    addr_q <= addr_d;
    bc_q   <= bc_d;
  end

  ddram_arb_tagfifo #(.DEPTH(RD_DEPTH)) u_tagfifo (
    .clk   (ram_clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata (tag_t'{id: grant_q, len: g_bc}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ddram_arb.sv
// Scoreboard bench for ddram_arb: bus-functional masters, a simple in-order memory model.
module tb_ddram_arb;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic              ram_clk = 1'b0;
  logic              reset_n;
  logic [2*AW-1:0]   m_address;
  logic [2*BW-1:0]   m_burstcount;
  logic [1:0]        m_read, m_write;
  logic [2*DW-1:0]   m_writedata;
  logic [2*DW/8-1:0] m_byteenable;
  logic [1:0]        m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     ram_address;
  logic [BW-1:0]     ram_burstcount;
  logic              ram_read, ram_write, ram_waitrequest, ram_readdatavalid, rd_orphan;
  logic [DW-1:0]     ram_writedata, ram_readdata, resp_data;
  logic [DW/8-1:0]   ram_byteenable;
  logic              resp_vld, inj_vld;

  assign ram_readdatavalid = resp_vld | inj_vld;
  assign ram_readdata      = resp_data;

  ddram_arb dut (
    .ram_clk           (ram_clk),
    .reset_n           (reset_n),
    .m_address         (m_address),
    .m_burstcount      (m_burstcount),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_writedata       (m_writedata),
    .m_byteenable      (m_byteenable),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .ram_address       (ram_address),
    .ram_burstcount    (ram_burstcount),
    .ram_read          (ram_read),
    .ram_write         (ram_write),
    .ram_writedata     (ram_writedata),
    .ram_byteenable    (ram_byteenable),
    .ram_waitrequest   (ram_waitrequest),
    .ram_readdata      (ram_readdata),
    .ram_readdatavalid (ram_readdatavalid),
    .rd_orphan         (rd_orphan)
  );

  always #5 ram_clk = ~ram_clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] exp_rd0[$];
  logic [63:0] exp_rd1[$];
  logic [63:0] ret_q[$];
  int          cmd_log[$];
  int          wr_beats = 0;
  int          rd_beats = 0;
  int          mark_wr[2];
  int          mark_rd[2];
  bit          rd_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dfn(input logic [AW-1:0] a, input int k, input bit w);
    return {(w ? 8'hA5 : 8'h5A), 3'b000, a, k[23:0]};
  endfunction

  function automatic int eff(input int bc);
    return (bc == 0) ? 1 : bc;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the command is accepted.
  task automatic rd(input int id, input logic [AW-1:0] a, input int bc);
    bit w;
    int t = 0;
    m_address[id*AW +: AW]    = a;
    m_burstcount[id*BW +: BW] = bc[BW-1:0];
    m_read[id]                = 1'b1;
    do begin
      @(negedge ram_clk);
      w = m_waitrequest[id];
      @(posedge ram_clk);
      t++;
    end while (w && t < 400);
    check("rd_accept", 64'(w), 64'd0);
    if (!w) begin
      for (int k = 0; k < eff(bc); k++) begin
        if (id == 0) exp_rd0.push_back(dfn(a, k, 1'b0));
        else         exp_rd1.push_back(dfn(a, k, 1'b0));
      end
      cmd_log.push_back(id);
      mark_wr[id] = wr_beats;
      mark_rd[id] = rd_beats;
    end
    #1;
    m_read[id] = 1'b0;
  endtask

  task automatic wr(input int id, input logic [AW-1:0] a, input int bc);
    bit w;
    int t;
    m_address[id*AW +: AW]    = a;
    m_burstcount[id*BW +: BW] = bc[BW-1:0];
    m_write[id]               = 1'b1;
    for (int k = 0; k < eff(bc); k++) begin
      m_writedata[id*DW +: DW] = dfn(a, k, 1'b1);
      t = 0;
      do begin
        @(negedge ram_clk);
        w = m_waitrequest[id];
        @(posedge ram_clk);
        t++;
      end while (w && t < 400);
      check("wr_accept", 64'(w), 64'd0);
      if (!w && k == 0) cmd_log.push_back(id);
      #1;
      if (w) break;
    end
    m_write[id] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((ret_q.size() > 0 || exp_rd0.size() > 0 || exp_rd1.size() > 0 || resp_vld) && t < 500) begin
      @(posedge ram_clk);
      t++;
    end
    check("drain", 64'(exp_rd0.size() + exp_rd1.size()), 64'd0);
    repeat (2) @(posedge ram_clk);
    #1;
  endtask

  // Memory model: in-order read returns, write beat checking.
  initial begin : mem_model
    logic [AW-1:0] w_addr;
    int w_left = 0;
    int w_k = 0;
    forever begin
      @(negedge ram_clk);
      if (!reset_n) begin
        ret_q.delete();
        w_left = 0;
      end else begin
        if (ram_read && !ram_waitrequest)
          for (int k = 0; k < eff(int'(ram_burstcount)); k++)
            ret_q.push_back(dfn(ram_address, k, 1'b0));
        if (ram_write && !ram_waitrequest) begin
          if (w_left == 0) begin
            w_addr = ram_address;
            w_left = eff(int'(ram_burstcount));
            w_k    = 0;
          end else begin
            check("wr_addr_hold", 64'(ram_address), 64'(w_addr));
          end
          check("wr_data", ram_writedata, dfn(w_addr, w_k, 1'b1));
          w_k++;
          w_left--;
          wr_beats++;
        end
      end
      @(posedge ram_clk);
      #1;
      if (reset_n && rd_en && ret_q.size() > 0) begin
        resp_vld  = 1'b1;
        resp_data = ret_q.pop_front();
      end else begin
        resp_vld = 1'b0;
      end
    end
  end

  initial begin : rd_monitor
    forever begin
      @(negedge ram_clk);
      if (|m_readdatavalid) check("rdv_onehot", 64'($countones(m_readdatavalid)), 64'd1);
      if (m_readdatavalid[0]) begin
        rd_beats++;
        check("rd0_pending", 64'(exp_rd0.size() > 0), 64'd1);
        if (exp_rd0.size() > 0) check("rd0_data", m_readdata, exp_rd0.pop_front());
      end
      if (m_readdatavalid[1]) begin
        rd_beats++;
        check("rd1_pending", 64'(exp_rd1.size() > 0), 64'd1);
        if (exp_rd1.size() > 0) check("rd1_data", m_readdata, exp_rd1.pop_front());
      end
    end
  end

  initial begin : main
    int  n0, base, rdb0, k, t;
    bit  w;
    reset_n         = 1'b0;
    m_address       = '0;
    m_burstcount    = '0;
    m_read          = '0;
    m_write         = '0;
    m_writedata     = '0;
    m_byteenable    = '1;
    ram_waitrequest = 1'b0;
    resp_vld        = 1'b0;
    inj_vld         = 1'b0;
    resp_data       = '0;
    rd_en           = 1'b1;
    repeat (3) @(posedge ram_clk);
    #1;
    check("rst_ram_read", 64'(ram_read), 64'd0);
    check("rst_ram_write", 64'(ram_write), 64'd0);
    check("rst_waitreq", 64'(m_waitrequest), 64'd3);
    check("rst_rdvalid", 64'(m_readdatavalid), 64'd0);
    check("rst_orphan", 64'(rd_orphan), 64'd0);
    @(negedge ram_clk);
    reset_n = 1'b1;
    @(posedge ram_clk);
    #1;

    // Simultaneous reads of burst 4 from both masters
    fork
      rd(0, 29'h100, 4);
      rd(1, 29'h200, 4);
    join
    check("t1_first", 64'(cmd_log[0]), 64'd0);
    check("t1_second", 64'(cmd_log[1]), 64'd1);
    drain();
    check("t1_beats", 64'(rd_beats), 64'd8);

    // Write burst 3 with a 2-cycle stall on beat 2, competing read from master 1
    base = wr_beats;
    n0   = cmd_log.size();
    fork
      wr(0, 29'h300, 3);
      begin
        @(posedge ram_clk);
        #1;
        rd(1, 29'h400, 2);
      end
      begin
        t = 0;
        while (wr_beats < base + 1 && t < 100) begin
          @(posedge ram_clk);
          t++;
        end
        #1;
        ram_waitrequest = 1'b1;
        repeat (2) @(posedge ram_clk);
        #1;
        ram_waitrequest = 1'b0;
      end
    join
    check("t2_wr_beats", 64'(wr_beats - base), 64'd3);
    check("t2_rd_after_wr", 64'(mark_wr[1] - base), 64'd3);
    check("t2_order0", 64'(cmd_log[n0]), 64'd0);
    check("t2_order1", 64'(cmd_log[n0+1]), 64'd1);
    drain();

    // Fill the tag FIFO, 5th read must wait while a write still gets through
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) rd(1, 29'h500 + 29'(i * 16), 2);
    n0   = cmd_log.size();
    rdb0 = rd_beats;
    fork
      rd(1, 29'h600, 2);
      begin
        repeat (3) @(posedge ram_clk);
        #1;
        wr(0, 29'h700, 1);
        repeat (5) @(posedge ram_clk);
        #1;
        rd_en = 1'b1;
      end
    join
    check("t3_wr_first", 64'(cmd_log[n0]), 64'd0);
    check("t3_rd_second", 64'(cmd_log[n0+1]), 64'd1);
    check("t3_unblock", 64'(mark_rd[1] - rdb0 >= 2), 64'd1);
    drain();

    // Read data with nothing outstanding
    check("t4_orphan_pre", 64'(rd_orphan), 64'd0);
    inj_vld = 1'b1;
    @(negedge ram_clk);
    check("t4_no_fwd", 64'(m_readdatavalid), 64'd0);
    @(posedge ram_clk);
    #1;
    inj_vld = 1'b0;
    check("t4_orphan", 64'(rd_orphan), 64'd1);
    repeat (3) @(posedge ram_clk);
    #1;
    check("t4_sticky", 64'(rd_orphan), 64'd1);

    // Reset during a write burst with 2 beats left
    base                       = wr_beats;
    m_address[AW-1:0]          = 29'h800;
    m_burstcount[BW-1:0]       = 8'd4;
    m_writedata[DW-1:0]        = dfn(29'h800, 0, 1'b1);
    m_write[0]                 = 1'b1;
    k = 0;
    t = 0;
    while (k < 2 && t < 100) begin
      @(negedge ram_clk);
      w = m_waitrequest[0];
      @(posedge ram_clk);
      t++;
      if (!w) k++;
      #1;
      m_writedata[DW-1:0] = dfn(29'h800, k, 1'b1);
    end
    check("t5_beats_pre", 64'(wr_beats - base), 64'd2);
    reset_n = 1'b0;
    #1;
    check("t5_ram_write", 64'(ram_write), 64'd0);
    check("t5_waitreq", 64'(m_waitrequest), 64'd3);
    check("t5_orphan_clr", 64'(rd_orphan), 64'd0);
    m_write = '0;
    repeat (2) @(posedge ram_clk);
    @(negedge ram_clk);
    reset_n = 1'b1;
    @(posedge ram_clk);
    #1;
    rd(1, 29'h900, 5);
    drain();
    check("t5_no_orphan", 64'(rd_orphan), 64'd0);

    // Both masters request back-to-back single writes
    n0 = cmd_log.size();
    fork
      begin
        for (int i = 0; i < 4; i++) wr(0, 29'hA00, 1);
      end
      begin
        for (int i = 0; i < 4; i++) wr(1, 29'hB00, 1);
      end
    join
    for (int i = 0; i < 8; i++) begin
`ifdef DDRAM_ARB_PRIO_EN
      check("t6_grant", 64'(cmd_log[n0+i]), 64'((i < 4) ? 0 : 1));
`else
      check("t6_grant", 64'(cmd_log[n0+i]), 64'(i % 2));
`endif
    end
    repeat (3) @(posedge ram_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ddram_arb.md
Name: ddram_arb

Overview:
- Two-requester arbiter that shares one 64-bit Avalon-MM DDR3 port of the HPS memory bridge (ram2_*) between two core-side masters.
- Typical masters: audio/ROM streamer and save-state engine.
- Grants whole commands: one read command, or a write command plus all of its burst beats.
- Tags outstanding reads so returning data reaches the master that issued them.
- Instantiated in the ram2 clock domain, between the core masters and the memory bridge.

Parameters:
- AW, 29, word address width.
- DW, 64, data width; byteenable width is DW/8.
- BW, 8, burstcount width.
- RD_DEPTH, 4, maximum outstanding read commands (tag FIFO depth, power of 2).

Ports:
- ram_clk  in  1  memory-port clock; all logic in this domain.
- reset_n  in  1  asynchronous active-low reset.
- m_address  in  2xAW  per-requester address.
- m_burstcount  in  2xBW  per-requester burst length.
- m_read  in  2  read request.
- m_write  in  2  write request / write beat valid.
- m_writedata  in  2xDW  write data.
- m_byteenable  in  2xDW/8  byte enables.
- m_waitrequest  out  2  per-requester stall.
- m_readdata  out  DW  shared read data.
- m_readdatavalid  out  2  per-requester data valid.
- ram_address  out  AW  to memory.
- ram_burstcount  out  BW  to memory.
- ram_read  out  1  to memory.
- ram_write  out  1  to memory.
- ram_writedata  out  DW  to memory.
- ram_byteenable  out  DW/8  to memory.
- ram_waitrequest  in  1  from memory.
- ram_readdata  in  DW  from memory.
- ram_readdatavalid  in  1  from memory.
- rd_orphan  out  1  sticky: read data returned with no tag outstanding.

Behaviour:
- Reset values:
  - state IDLE; grant 0; last-winner 1, so requester 0 wins first.
  - ram_read/ram_write 0.
  - m_waitrequest 2'b11.
  - m_readdatavalid 0.
  - tag FIFO empty; return beat counter 0; rd_orphan 0.
- Eligibility:
  - A requester is eligible when m_read or m_write is set.
  - A read is eligible only if the tag FIFO is not full.
  - A requester asserting both read and write is treated as write.
- FSM IDLE:
  - If any requester is eligible, register the winner into grant and go to ISSUE.
  - Round-robin: prefer the requester that did not win last.
  - Memory outputs are 0/idle in IDLE.
- FSM ISSUE:
  - Memory outputs are combinationally muxed from the granted requester.
  - m_waitrequest[grant] = ram_waitrequest; the other requester sees 1.
  - Command completes on the cycle ram_read|ram_write is high and ram_waitrequest is low.
  - Read completes: push {grant, burstcount} into the tag FIFO; return to IDLE.
  - Write completes with burstcount<=1: return to IDLE.
  - Write completes with burstcount>1: load beat counter with burstcount-1; go to WBURST.
  - burstcount 0 is illegal and handled as 1.
- FSM WBURST:
  - Forward the granted requester's write beats.
  - Decrement on each accepted beat (ram_write & !ram_waitrequest).
  - At 0, go to IDLE.
  - ram_address/ram_burstcount are held from the first beat.
  - Gaps where m_write is low are allowed.
- Last-winner updates on command completion, not at grant.
- Arbitration latency: 1 idle cycle between commands, so minimum 2 cycles per command.
- Read return:
  - Tag FIFO head gives the id and burst length.
  - Each ram_readdatavalid asserts m_readdatavalid[head id] in the same cycle (combinational); m_readdata = ram_readdata.
  - On the final beat of a burst, pop the head.
  - A push and a pop in the same cycle are both honoured (no count change).
- Read data arriving with the FIFO empty: drop it and set rd_orphan (cleared only by reset).
- Read returns proceed in parallel with a new command issue or a write burst.
- Reset mid-operation clears the FSM and FIFO immediately; in-flight read data is discarded and is not flagged after reset.

Optional Feature:
- DDRAM_ARB_PRIO_EN defined: fixed priority, requester 0 always wins over requester 1; last-winner register removed.
- Undefined: round-robin as above.
- The read-FIFO-full eligibility rule applies in both modes.

Decomposition:
- Package ddram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WBURST);
  - tag struct {logic id; logic [BW-1:0] len};
  - default width constants.
- One sub-module: ddram_arb_tagfifo, a synchronous FIFO with depth RD_DEPTH of tag structs, exposing full/empty, same-cycle push+pop, and async active-low reset.

Test Plan:
- Both masters read burstcount 4 in the same cycle after reset; memory returns 8 beats → first 4 beats on m_readdatavalid[0], next 4 on [1]; commands issued in order 0 then 1.
- Master 0 writes burst 3 with ram_waitrequest high on beat 2 for 2 cycles, while master 1 requests a read → master 1 stays stalled until the third beat is accepted; exactly 3 ram_write accepts; then the read is issued.
- Master 1 issues 4 reads with no data returned (FIFO full, RD_DEPTH=4) → 5th read held; a master 0 write is still granted; first returned beat unblocks the read after its burst completes.
- ram_readdatavalid pulse with no outstanding read → data not forwarded, rd_orphan=1 and sticky.
- reset_n low during a WBURST with 2 beats remaining → ram_write=0, m_waitrequest=2'b11 immediately; after release, a new master 1 read goes out with burstcount unchanged.
- With DDRAM_ARB_PRIO_EN, both masters request continuously → grant sequence 0,0,0…; without it → 0,1,0,1.
